alu_seq_ctrl: RTL

//  Multi-byte sequencer for the 8-bit combinational ALU. Accepts one WORDS-byte command
//  (ADD/LSH/RSH/XOR/AND), then drives the ALU one byte per cycle, chaining SC_OUT->SC_IN.

---
 rtl/alu_seq_ctrl_pkg.sv | 18 +
 rtl/alu_seq_ctrl.sv | 137 +++++++++++++
 2 files changed

// File: rtl/alu_seq_ctrl_pkg.sv
// Shared types for the byte-serial ALU sequencer: ALU opcode mnemonics and sequencer states.
package alu_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    kADD = 3'd0,
    kLSH = 3'd1,
    kRSH = 3'd2,
    kXOR = 3'd3,
    kAND = 3'd4
  } op_mne;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } seq_state_t;

endpackage

// File: rtl/alu_seq_ctrl.sv
// Drives an external 8-bit ALU one byte per cycle to execute a WORDS-byte command.
// Optional macro ALU_SEQ_OVF_EN adds a two's-complement overflow output for ADD.
module alu_seq_ctrl
  import alu_seq_ctrl_pkg::*;
#(
  parameter int WORDS = 2
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               START,
  input  logic [2:0]         CMD_OP,
  input  logic               CIN,
  input  logic [8*WORDS-1:0] OPA,
  input  logic [8*WORDS-1:0] OPB,
  input  logic               ABORT,
  output logic               BUSY,
  output logic               DONE,
  output logic [8*WORDS-1:0] RESULT,
  output logic               CARRY,
  output logic               ZF,
  output logic [7:0]         ALU_A,
  output logic [7:0]         ALU_B,
  output logic [2:0]         ALU_OP,
  output logic               ALU_SC_IN,
  input  logic [7:0]         ALU_OUT,
  input  logic               ALU_SC_OUT,
  input  logic               ALU_ZERO
`ifdef ALU_SEQ_OVF_EN
  ,
  output logic               OVF
`endif
);

  localparam int W  = 8 * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  seq_state_t      state, nxt;
  logic [IW-1:0]   idx;
  logic [W-1:0]    opa_q, opb_q, res_acc, res_q;
  logic [2:0]      op_q;
  logic            cry, zacc, carry_q, zf_q;
  logic            accept, done, last, is_rsh;

  assign accept = (state == S_IDLE) && START && !ABORT;
  assign done   = (state == S_FIN) && !ABORT;
  assign is_rsh = (op_q == kRSH);
  assign last   = is_rsh ? (idx == '0) : (idx == IW'(WORDS - 1));

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  if (accept) nxt = S_RUN;
      S_RUN:   if (ABORT) nxt = S_IDLE; else if (last) nxt = S_FIN;
      S_FIN:   nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ALU_A     = '0;
    ALU_B     = '0;
    ALU_OP    = '0;
    ALU_SC_IN = 1'b0;
    if (state == S_RUN) begin
      ALU_A     = opa_q[int'(idx)*8 +: 8];
      ALU_B     = opb_q[int'(idx)*8 +: 8];
      ALU_OP    = op_q;
      ALU_SC_IN = cry;
    end
  end

`ifdef ALU_SEQ_OVF_EN
  logic ovf_acc, ovf_q;
  assign OVF = done ? ovf_acc : ovf_q;
`endif

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state   <= S_IDLE;
      idx     <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      op_q    <= '0;
      res_acc <= '0;
      res_q   <= '0;
      cry     <= 1'b0;
      zacc    <= 1'b0;
      carry_q <= 1'b0;
      zf_q    <= 1'b0;
`ifdef ALU_SEQ_OVF_EN
      ovf_acc <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state <= nxt;
      if (accept) begin
        opa_q   <= OPA;
        opb_q   <= OPB;
        op_q    <= CMD_OP;
        cry     <= CIN;
        zacc    <= 1'b1;
        res_acc <= '0;
        idx     <= (CMD_OP == kRSH) ? IW'(WORDS - 1) : '0;
`ifdef ALU_SEQ_OVF_EN
        ovf_acc <= 1'b0;
`endif
      end
      if (state == S_RUN) begin
        res_acc[int'(idx)*8 +: 8] <= ALU_OUT;
        cry  <= ALU_SC_OUT;
        zacc <= zacc & ALU_ZERO;
        if (!last) idx <= is_rsh ? idx - IW'(1) : idx + IW'(1);
`ifdef ALU_SEQ_OVF_EN
        // Sign bits of the top byte give the whole-word overflow for ADD.
        if (op_q == kADD && idx == IW'(WORDS - 1))
          ovf_acc <= (ALU_A[7] == ALU_B[7]) && (ALU_OUT[7] != ALU_A[7]);
`endif
      end
      // Visible outputs only change on a completed command, so ABORT keeps the old result.
      if (done) begin
        res_q   <= res_acc;
        carry_q <= cry;
        zf_q    <= zacc;
`ifdef ALU_SEQ_OVF_EN
        ovf_q   <= ovf_acc;
`endif
      end
    end
  end

  assign BUSY   = (state != S_IDLE);
  assign DONE   = done;
  assign RESULT = done ? res_acc : res_q;
  assign CARRY  = done ? cry     : carry_q;
  assign ZF     = done ? zacc    : zf_q;

endmodule
